// File: rtl/cdma_pkg.sv
// Shared constants and types for the 4-user CDMA link.
// Contents:
//   - user count, code length and word size
//   - the legal maximum of the chip-sum stream
//   - the four orthogonal spreading codes
//   - the receiver FSM state type
//   - the chip-sum to signed chip-metric mapping
// The transmitter's pn_sequence uses the same SPREAD_CODES table, so both
// ends of the link agree on which code belongs to which user.
package cdma_pkg;

    localparam int NUM_USERS     = 4;
    localparam int CHIPS_PER_BIT = 4;
    localparam int BITS_PER_WORD = 4;
    localparam int ACC_W         = 6;
    localparam int METRIC_W      = 4;
    localparam int CNT_W         = 2;

    localparam logic [7:0]       CHIP_SUM_MAX = 8'd4;
    localparam logic [CNT_W-1:0] LAST_CHIP    = 2'd3;
    localparam logic [CNT_W-1:0] LAST_BIT     = 2'd3;

    typedef logic [CHIPS_PER_BIT-1:0] code_t;

    // Bit i of each code is chip i. Index 0 is user1.
    // In chip order (chip 0 first):
    //   user1 = 0000, user2 = 0101, user3 = 0011, user4 = 0110
    localparam code_t [NUM_USERS-1:0] SPREAD_CODES = {4'b0110, 4'b1100, 4'b1010, 4'b0000};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // The chip sum counts users sending '1'. This returns the bipolar sum
    // (+1 per '0' chip, -1 per '1' chip), i.e. 4 - 2*sum.
    // Sums above the legal maximum are treated as the maximum.
    function automatic logic signed [METRIC_W-1:0] chip_metric(input logic [7:0] chip_sum);
        logic signed [METRIC_W-1:0] m;
        if (chip_sum > CHIP_SUM_MAX) begin
            m = -4'sd4;
        end else begin
            case (chip_sum[2:0])
                3'd0:    m = 4'sd4;
                3'd1:    m = 4'sd2;
                3'd2:    m = 4'sd0;
                3'd3:    m = -4'sd2;
                default: m = -4'sd4;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/cdma_if.sv
// Chip-stream and word-output bundle between the CDMA chip source and the
// receiver.
// Modports:
//   master : drives spread_in, in_valid and sof; observes the results.
//   slave  : the receiver; consumes the chip stream and drives
//            user1..4_data, out_valid, bit_err and frame_err.
interface cdma_if;

    logic [7:0] spread_in;
    logic       in_valid;
    logic       sof;
    logic [3:0] user1_data;
    logic [3:0] user2_data;
    logic [3:0] user3_data;
    logic [3:0] user4_data;
    logic       out_valid;
    logic       bit_err;
    logic       frame_err;

    modport master (
        output spread_in, in_valid, sof,
        input  user1_data, user2_data, user3_data, user4_data,
        input  out_valid, bit_err, frame_err
    );

    modport slave (
        input  spread_in, in_valid, sof,
        output user1_data, user2_data, user3_data, user4_data,
        output out_valid, bit_err, frame_err
    );

endinterface

// File: rtl/cdma_correlator.sv
// One user's despreading correlator.
// Accumulates +/- chip metric according to the user's code bit and decides
// the data bit on the last chip of each bit period.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   metric    : signed chip metric for the current chip
//   code_bit  : this user's code bit for the current chip position
//   strobe    : the current chip is accepted
//   last      : the current chip is the last chip of a bit (acc clears)
//   clear     : the current chip starts a new frame (old acc discarded)
//   bit_out   : decided bit (total < 0 -> 1); meaningful with strobe & last
//   amb_out   : total == 0; meaningful with strobe & last
module cdma_correlator
    import cdma_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [METRIC_W-1:0] metric,
    input  logic                       code_bit,
    input  logic                       strobe,
    input  logic                       last,
    input  logic                       clear,
    output logic                       bit_out,
    output logic                       amb_out
);

    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] base_s;
    logic signed [ACC_W-1:0] ext_s;
    logic signed [ACC_W-1:0] total_s;

    // Running total including the current chip; a frame start ignores stale acc.
    always_comb begin
        base_s  = clear ? {ACC_W{1'b0}} : acc_r;
        ext_s   = {{(ACC_W-METRIC_W){metric[METRIC_W-1]}}, metric};
        total_s = code_bit ? (base_s - ext_s) : (base_s + ext_s);
        bit_out = total_s[ACC_W-1];
        amb_out = (total_s == {ACC_W{1'b0}});
    end

    // Accumulator register: restarts after each decided bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (strobe) begin
            acc_r <= last ? {ACC_W{1'b0}} : total_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/cdma_receiver.sv
// 4-user CDMA despreader.
// Takes the chip-sum stream, correlates it against every user's code,
// decides one bit per 4 chips and assembles one 4-bit word per user per
// 16-chip frame.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : cdma_if.slave
//              in : spread_in, in_valid, sof
//              out: user1..4_data, out_valid, bit_err, frame_err
//              All outputs are registered and appear one cycle after the
//              chip that caused them.
module cdma_receiver
    import cdma_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    cdma_if.slave  bus
);

    state_t                                        state_r;
    logic [CNT_W-1:0]                              chip_cnt_r;
    logic [CNT_W-1:0]                              bit_cnt_r;
    logic [NUM_USERS-1:0][BITS_PER_WORD-1:0]       sipo_r;
    logic [NUM_USERS-1:0][BITS_PER_WORD-1:0]       user_data_r;
    logic                                          out_valid_r;
    logic                                          bit_err_r;
    logic                                          frame_err_r;

    logic                                          start_s;
    logic                                          proc_s;
    logic                                          abort_s;
    logic [CNT_W-1:0]                              pos_chip_s;
    logic [CNT_W-1:0]                              pos_bit_s;
    logic                                          last_chip_s;
    logic                                          frame_done_s;
    logic                                          range_err_s;
    logic signed [METRIC_W-1:0]                    metric_s;
    logic [NUM_USERS-1:0]                          code_bit_s;
    logic [NUM_USERS-1:0]                          dec_bit_s;
    logic [NUM_USERS-1:0]                          amb_s;
    logic [NUM_USERS-1:0][BITS_PER_WORD-1:0]       next_word_s;

    // Frame position of the current chip; a sof chip is always chip 0 of bit 0.
    always_comb begin
        start_s  = bus.in_valid & bus.sof;
        proc_s   = bus.in_valid & (bus.sof | (state_r == ST_RUN));
        abort_s  = start_s & (state_r == ST_RUN) &
                   ((chip_cnt_r != 2'd0) | (bit_cnt_r != 2'd0));
        if (start_s) begin
            pos_chip_s = 2'd0;
            pos_bit_s  = 2'd0;
        end else begin
            pos_chip_s = chip_cnt_r;
            pos_bit_s  = bit_cnt_r;
        end
        last_chip_s  = proc_s & (pos_chip_s == LAST_CHIP);
        frame_done_s = last_chip_s & (pos_bit_s == LAST_BIT);
        range_err_s  = proc_s & (bus.spread_in > CHIP_SUM_MAX);
        metric_s     = chip_metric(bus.spread_in);
        for (int k = 0; k < NUM_USERS; k++) begin
            code_bit_s[k]  = SPREAD_CODES[k][pos_chip_s];
            next_word_s[k] = {sipo_r[k][BITS_PER_WORD-2:0], dec_bit_s[k]};
        end
    end

    for (genvar k = 0; k < NUM_USERS; k++) begin : g_corr
        cdma_correlator u_corr (
            .clk      (clk),
            .rst      (rst),
            .metric   (metric_s),
            .code_bit (code_bit_s[k]),
            .strobe   (proc_s),
            .last     (last_chip_s),
            .clear    (start_s),
            .bit_out  (dec_bit_s[k]),
            .amb_out  (amb_s[k])
        );
    end

    // Frame FSM, chip/bit counters, SIPOs and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            chip_cnt_r  <= 2'd0;
            bit_cnt_r   <= 2'd0;
            sipo_r      <= {(NUM_USERS*BITS_PER_WORD){1'b0}};
            user_data_r <= {(NUM_USERS*BITS_PER_WORD){1'b0}};
            out_valid_r <= 1'b0;
            bit_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            out_valid_r <= frame_done_s;
            bit_err_r   <= range_err_s | (last_chip_s & (|amb_s));
            frame_err_r <= abort_s;
            if (proc_s) begin
                if (frame_done_s) begin
                    state_r     <= ST_IDLE;
                    chip_cnt_r  <= 2'd0;
                    bit_cnt_r   <= 2'd0;
                    user_data_r <= next_word_s;
                end else begin
                    state_r    <= ST_RUN;
                    chip_cnt_r <= pos_chip_s + 2'd1;
                    bit_cnt_r  <= last_chip_s ? (pos_bit_s + 2'd1) : pos_bit_s;
                end
                // Partial bits of an aborted frame are shifted out by the new frame.
                if (last_chip_s) begin
                    sipo_r <= next_word_s;
                end
            end
        end
    end

    assign bus.user1_data = user_data_r[0];
    assign bus.user2_data = user_data_r[1];
    assign bus.user3_data = user_data_r[2];
    assign bus.user4_data = user_data_r[3];
    assign bus.out_valid  = out_valid_r;
    assign bus.bit_err    = bit_err_r;
    assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_cdma_receiver.sv
// Self-checking bench for cdma_receiver.
// A frame-level model predicts, for every clock edge, the expected
// out_valid / bit_err / frame_err and the word set held on the outputs.
// A negedge process compares the DUT against that prediction every cycle.
module tb_cdma_receiver;

    localparam int MAXC = 2048;

    logic clk = 1'b0;
    logic rst;
    cdma_if bus_if ();

    cdma_receiver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    bit          exp_ov  [MAXC];
    bit          exp_be  [MAXC];
    bit          exp_fe  [MAXC];
    bit          exp_rst [MAXC];
    logic [15:0] exp_w   [MAXC];

    int n_cmp = 0;
    int n_bad = 0;

    // Codes in chip order, chip 0 first, users 1..4.
    int code_tab [4][4] = '{'{0,0,0,0}, '{0,1,0,1}, '{0,0,1,1}, '{0,1,1,0}};

    // Frame-level model state.
    int   mq [$];
    bit   in_frame = 1'b0;
    int   mw_u [4];

    logic [15:0] held = 16'h0000;
    int          ov_edges [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    // Transmitter rule: chip sum = number of users with d ^ code = 1.
    function automatic int tx_chip(input logic [15:0] w, input int b, input int c);
        int s;
        logic [3:0] nib;
        s = 0;
        for (int u = 0; u < 4; u++) begin
            nib = w[15-4*u -: 4];
            s += (int'(nib[3-b]) ^ code_tab[u][c]);
        end
        return s;
    endfunction

    function automatic int metric(input int x);
        return 4 - 2 * ((x > 4) ? 4 : x);
    endfunction

    function automatic int bit_total(input int ch [4], input int u);
        int t;
        t = 0;
        for (int c = 0; c < 4; c++)
            t += (code_tab[u][c] != 0) ? -metric(ch[c]) : metric(ch[c]);
        return t;
    endfunction

    task automatic build(input logic [15:0] w, output int ch [16]);
        for (int i = 0; i < 16; i++) ch[i] = tx_chip(w, i / 4, i % 4);
    endtask

    task automatic idle(input int n);
        bus_if.in_valid = 1'b0;
        bus_if.sof      = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.sof      = 1'b0;
        mq.delete();
        in_frame = 1'b0;
        repeat (n) begin
            exp_rst[edge_cnt + 1] = 1'b1;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // Drive one valid chip and record what the DUT must show after this edge.
    task automatic send(input int chip, input bit s);
        int t;
        int ch4 [4];
        int tot;
        logic [15:0] pk;
        t = edge_cnt + 1;
        bus_if.in_valid  = 1'b1;
        bus_if.spread_in = 8'(chip);
        bus_if.sof       = s;
        if (s) begin
            if (in_frame) exp_fe[t] = 1'b1;
            mq.delete();
            in_frame = 1'b1;
            for (int u = 0; u < 4; u++) mw_u[u] = 0;
        end
        if (in_frame) begin
            mq.push_back(chip);
            if (chip > 4) exp_be[t] = 1'b1;
            if (mq.size() % 4 == 0) begin
                for (int c = 0; c < 4; c++) ch4[c] = mq[mq.size() - 4 + c];
                for (int u = 0; u < 4; u++) begin
                    tot = bit_total(ch4, u);
                    if (tot == 0) exp_be[t] = 1'b1;
                    mw_u[u] = ((mw_u[u] << 1) | ((tot < 0) ? 1 : 0)) & 15;
                end
            end
            if (mq.size() == 16) begin
                pk = {mw_u[0][3:0], mw_u[1][3:0], mw_u[2][3:0], mw_u[3][3:0]};
                exp_ov[t] = 1'b1;
                exp_w[t]  = pk;
                in_frame  = 1'b0;
                mq.delete();
            end
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.sof      = 1'b0;
    endtask

    task automatic send_list(input int ch [16], input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gap_max > 0) idle($urandom_range(0, gap_max));
            send(ch[i], i == 0);
        end
    endtask

    function automatic logic [15:0] dut_words();
        return {bus_if.user1_data, bus_if.user2_data, bus_if.user3_data, bus_if.user4_data};
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (edge_cnt > 0 && edge_cnt < MAXC) begin
            if (exp_rst[edge_cnt]) held = 16'h0000;
            if (exp_ov[edge_cnt])  held = exp_w[edge_cnt];
            check("out_valid", {31'd0, bus_if.out_valid}, {31'd0, exp_ov[edge_cnt]});
            check("bit_err",   {31'd0, bus_if.bit_err},   {31'd0, exp_be[edge_cnt]});
            check("frame_err", {31'd0, bus_if.frame_err}, {31'd0, exp_fe[edge_cnt]});
            check("words",     {16'd0, dut_words()},      {16'd0, held});
            if (bus_if.out_valid === 1'b1) ov_edges.push_back(edge_cnt);
        end
    end

    initial begin
        int ch [16];
        int ch2 [16];
        int pin4 [4];
        rst              = 1'b1;
        bus_if.spread_in = 8'd0;
        bus_if.in_valid  = 1'b0;
        bus_if.sof       = 1'b0;
        do_reset(3);

        // Hand-computed pins on the model.
        check("pin_enc_mix_c0",  tx_chip(16'hA6C1, 0, 0), 2);
        check("pin_enc_mix_c1",  tx_chip(16'hA6C1, 0, 1), 4);
        check("pin_enc_mix_c2",  tx_chip(16'hA6C1, 0, 2), 2);
        check("pin_enc_zero_c1", tx_chip(16'h0000, 2, 1), 2);
        check("pin_enc_ones_c0", tx_chip(16'hFFFF, 3, 0), 4);
        pin4 = '{7, 2, 2, 2};
        check("pin_dec_clamp_u1", bit_total(pin4, 0), -4);
        check("pin_dec_clamp_u4", bit_total(pin4, 3), -4);
        pin4 = '{2, 2, 2, 2};
        check("pin_dec_amb_u2", bit_total(pin4, 1), 0);

        // All users 0000.
        build(16'h0000, ch);
        send_list(ch, 16, 0);
        check("ov_latency_f1", {31'd0, bus_if.out_valid}, 32'd1);
        check("w_zero", {16'd0, dut_words()}, 32'h0000);
        idle(2);

        // All users 1111.
        build(16'hFFFF, ch);
        send_list(ch, 16, 0);
        check("w_ones", {16'd0, dut_words()}, 32'hFFFF);
        idle(2);

        // Mixed words with random gaps.
        build(16'hA6C1, ch);
        send_list(ch, 16, 3);
        check("ov_latency_gaps", {31'd0, bus_if.out_valid}, 32'd1);
        check("w_mixed", {16'd0, dut_words()}, 32'hA6C1);
        idle(2);

        // Out-of-range chip on bit 1, ambiguous chips on bit 3.
        build(16'h0000, ch);
        ch[4] = 7;
        for (int i = 12; i < 16; i++) ch[i] = 2;
        send_list(ch, 16, 0);
        check("w_clamped", {16'd0, dut_words()}, 32'h4444);
        idle(2);

        // sof at chip 9 aborts, the following frame decodes.
        build(16'h9999, ch);
        send_list(ch, 9, 0);
        build(16'h3C5A, ch2);
        send_list(ch2, 16, 1);
        check("w_after_abort", {16'd0, dut_words()}, 32'h3C5A);
        idle(2);

        // Reset at chip 5, then a clean frame.
        build(16'hABCD, ch);
        send_list(ch, 5, 0);
        do_reset(2);
        check("w_in_reset", {16'd0, dut_words()}, 32'h0000);
        check("ov_in_reset", {31'd0, bus_if.out_valid}, 32'd0);
        build(16'h1234, ch);
        send_list(ch, 16, 2);
        check("w_after_reset", {16'd0, dut_words()}, 32'h1234);
        idle(3);

        // Back-to-back frames.
        build(16'hA6C1, ch);
        send_list(ch, 16, 0);
        build(16'h5E0F, ch2);
        send_list(ch2, 16, 0);
        check("w_b2b", {16'd0, dut_words()}, 32'h5E0F);
        idle(3);

        check("ov_count", ov_edges.size(), 8);
        if (ov_edges.size() >= 2)
            check("b2b_spacing", ov_edges[ov_edges.size()-1] - ov_edges[ov_edges.size()-2], 16);
        else
            check("b2b_spacing", ov_edges.size(), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdma_receiver.md
Name: cdma_receiver

Overview:
- Despreading stage directly downstream of the 4-user CDMA transmitter. Consumes the 8-bit chip-sum stream (count of '1' chips across the 4 users, legal range 0..4).
- Correlates that stream against each user's orthogonal spreading code and makes a hard bit decision every 4 chips.
- Reassembles the bits into one 4-bit word per user, mirroring the transmitter's parallel inputs. Output is one word set per 16-chip frame.

Parameters:
- CHIPS_PER_BIT, 4, chips per data bit; the spreading code length.
- BITS_PER_WORD, 4, data bits per user word, sent MSB first.
- ACC_W, 6, signed correlator accumulator width; covers -16..+16.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- spread_in  in  8  chip-sum from the transmitter adder; 0..4 legal.
- in_valid  in  1  spread_in carries a chip this cycle.
- sof  in  1  qualified by in_valid; marks chip 0 of bit 0 (the MSB) of a frame.
- user1_data, user2_data, user3_data, user4_data  out  4 each  recovered words.
- out_valid  out  1  one-cycle pulse; the four words are valid this cycle.
- bit_err  out  1  one-cycle pulse on an ambiguous decision or an out-of-range chip.
- frame_err  out  1  one-cycle pulse when sof aborts a partial frame.

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, all counters and accumulators = 0. userN_data=0, out_valid=0, bit_err=0, frame_err=0.
- Spreading codes (constants), chip 0 first:
  - user1 = 0000
  - user2 = 0101
  - user3 = 0011
  - user4 = 0110
- Transmitted chip for user k is d_k XOR code_k[chip].
- Chip metric:
  - s = 4 - 2*min(spread_in,4), as a 4-bit signed value.
  - spread_in > 4 is clamped to 4 and raises a bit_err pulse.
- Correlation per user k, for each accepted chip:
  - Contribution = +s if code_k[chip]==0, otherwise -s.
  - acc_k is ACC_W signed.
  - Ideal result over 4 chips is +4 for bit 0 and -4 for bit 1.
- Decision, on chip 3 of each bit, using total = acc_k + contribution:
  - total < 0 -> bit 1; total > 0 -> bit 0.
  - total == 0 -> bit 0 and a bit_err pulse.
  - The bit shifts into user k's SIPO at the LSB, so the first bit ends up as the MSB.
  - acc_k clears in the same cycle.
- Only cycles with in_valid=1 advance chip_cnt (0..3) and bit_cnt (0..3). Gaps of any length are allowed; state holds during gaps.
- FSM:
  - IDLE: chips without sof are ignored. in_valid & sof -> RUN; that chip is processed as chip 0 of bit 0.
  - RUN: on the 16th accepted chip (bit_cnt=3, chip_cnt=3), the SIPO contents and final bits load into userN_data. out_valid pulses in the next cycle (latency 1 after the last chip). FSM -> IDLE.
  - RUN with in_valid & sof and not at frame position 0: discard the partial frame and pulse frame_err. Restart with this chip as chip 0 of bit 0. userN_data are unchanged.
- Back-to-back frames: sof on the chip immediately after the last chip is accepted without a gap.
- userN_data hold their value until the next completed frame.
- bit_err and frame_err are single-cycle and non-sticky. They may coincide with out_valid.
- rst mid-frame: partial data is lost and no out_valid is produced.

Decomposition:
- Package cdma_pkg holds:
  - The 4 spreading code constants, indexed by user.
  - CHIPS_PER_BIT, BITS_PER_WORD and the chip-sum legal maximum (4).
  - The FSM state enum.
  - The transmitter's pn_sequence shares these code constants.
- Sub-module cdma_correlator, instantiated 4 times:
  - Inputs: chip metric, code bit, chip strobe, last-chip flag, clear.
  - Outputs: decided bit and ambiguity flag; holds acc_k.
- Top-level owns the FSM, counters, range check and the SIPO/output registers.

Test Plan:
- All users 0000: frame chips repeat 0,2,2,2 ×4 with sof on the first chip -> out_valid once, one cycle after chip 16; all userN_data = 0000; no errors.
- All users 1111: chips repeat 4,2,2,2 -> all userN_data = 1111.
- Users 1010/0110/1100/0001: drive the transmitter model's expected chip sums, with in_valid low for random gaps -> exact words recovered; out_valid one cycle after the 16th valid chip.
- spread_in = 7 on one chip -> bit_err pulse, treated as 4, frame still completes.
- sof at chip 9 of a frame -> frame_err pulse, no out_valid for the aborted frame. The next 16 chips decode correctly.
- rst asserted at chip 5, then a clean frame -> all outputs 0 during reset; the clean frame decodes with exactly one out_valid. Also: two frames back-to-back -> two out_valid pulses 16 chips apart.
